hazard_detection_unit: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core. It covers the cases that operand forwarding cannot resolve: load-use dependencies, data-memory wait states and EX-stage control redirects. It emits stall, bubble, freeze and flush controls to the PC and to the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. A watchdog flags data-memory accesses that never complete.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_perf_counter.sv | 33 +++
 rtl/hazard_detection_unit.sv | 144 ++++++++++++++
 tb/tb_hazard_detection_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding and widths.
package hazard_pkg;

   localparam int unsigned REG_IDX_W = 5;
   localparam int unsigned CNT_W     = 32;
   localparam int unsigned WAIT_W    = 8;

   typedef logic [1:0] hazard_state_t;

   localparam hazard_state_t RUN      = 2'd0;
   localparam hazard_state_t MEM_WAIT = 2'd1;
   localparam hazard_state_t ERROR    = 2'd2;

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter with synchronous clear, used for hazard statistics.
module hazard_perf_counter
   import hazard_pkg::*;
#(
   parameter int unsigned W = CNT_W
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use / memory-wait / redirect hazard controller with data-memory watchdog.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_detection_unit
   import hazard_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [REG_IDX_W-1:0] ID_rs1,
   input  logic [REG_IDX_W-1:0] ID_rs2,
   input  logic                 ID_use_rs1,
   input  logic                 ID_use_rs2,
   input  logic [REG_IDX_W-1:0] ID_EX_rd,
   input  logic                 ID_EX_mem_read,
   input  logic                 EX_redirect,
   input  logic                 EX_MEM_mem_req,
   input  logic                 dmem_ready,
   output logic                 pc_write,
   output logic                 IF_ID_write,
   output logic                 ID_EX_write,
   output logic                 EX_MEM_write,
   output logic                 ID_EX_bubble,
   output logic                 MEM_WB_bubble,
   output logic                 IF_ID_flush,
   output logic                 ID_EX_flush,
   output logic                 mem_timeout,
   output logic [1:0]           state
`ifdef HAZARD_PERF_CNT_EN
  ,output logic [CNT_W-1:0]     load_use_cnt,
   output logic [CNT_W-1:0]     mem_wait_cnt,
   output logic [CNT_W-1:0]     flush_cnt
`endif
);

   localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

   hazard_state_t     state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              mem_timeout_q, mem_timeout_d;

   logic load_use;
   logic freeze_req;
   logic freeze_act;

   always_comb begin
      load_use = ID_EX_mem_read && (ID_EX_rd != '0) &&
                 ((ID_use_rs1 && (ID_rs1 == ID_EX_rd)) ||
                  (ID_use_rs2 && (ID_rs2 == ID_EX_rd)));
      freeze_req = EX_MEM_mem_req && !dmem_ready;

      // Once waiting, the freeze lasts until dmem_ready; ERROR freezes forever.
      unique case (state_q)
         MEM_WAIT: freeze_act = !dmem_ready;
         ERROR:    freeze_act = 1'b1;
         default:  freeze_act = freeze_req;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q;
      unique case (state_q)
         RUN: begin
            if (freeze_req) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = '0;
            end
         end
         MEM_WAIT: begin
            if (dmem_ready) begin
               state_d = RUN;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
               if (wait_cnt_d >= TIMEOUT_V) begin
                  state_d       = ERROR;
                  mem_timeout_d = 1'b1;
               end
            end
         end
         ERROR:   state_d = ERROR;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      pc_write      = 1'b1;
      IF_ID_write   = 1'b1;
      ID_EX_write   = 1'b1;
      EX_MEM_write  = 1'b1;
      ID_EX_bubble  = 1'b0;
      MEM_WB_bubble = 1'b0;
      IF_ID_flush   = 1'b0;
      ID_EX_flush   = 1'b0;
      if (freeze_act) begin
         pc_write      = 1'b0;
         IF_ID_write   = 1'b0;
         ID_EX_write   = 1'b0;
         EX_MEM_write  = 1'b0;
         MEM_WB_bubble = 1'b1;
      end else if (EX_redirect) begin
         IF_ID_flush = 1'b1;
         ID_EX_flush = 1'b1;
      end else if (load_use) begin
         pc_write     = 1'b0;
         IF_ID_write  = 1'b0;
         ID_EX_bubble = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= RUN;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   assign state       = state_q;
   assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
   logic lu_inc, mw_inc, fl_inc;
   assign lu_inc = !freeze_act && !EX_redirect && load_use;
   assign mw_inc = freeze_act;
   assign fl_inc = !freeze_act && EX_redirect;

   hazard_perf_counter #(.W(CNT_W)) u_load_use_cnt (
      .clk(clk), .clr(!reset), .inc(lu_inc), .cnt(load_use_cnt)
   );
   hazard_perf_counter #(.W(CNT_W)) u_mem_wait_cnt (
      .clk(clk), .clr(!reset), .inc(mw_inc), .cnt(mem_wait_cnt)
   );
   hazard_perf_counter #(.W(CNT_W)) u_flush_cnt (
      .clk(clk), .clr(!reset), .inc(fl_inc), .cnt(flush_cnt)
   );
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit (MEM_TIMEOUT = 4).
module tb_hazard_detection_unit;

   localparam int T = 4;
   localparam logic [7:0] C_RUN    = 8'b1111_0000;
   localparam logic [7:0] C_FREEZE = 8'b0000_0100;
   localparam logic [7:0] C_REDIR  = 8'b1111_0011;
   localparam logic [7:0] C_LU     = 8'b0011_1000;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] ID_rs1, ID_rs2, ID_EX_rd;
   logic       ID_use_rs1, ID_use_rs2, ID_EX_mem_read;
   logic       EX_redirect, EX_MEM_mem_req, dmem_ready;
   logic       pc_write, IF_ID_write, ID_EX_write, EX_MEM_write;
   logic       ID_EX_bubble, MEM_WB_bubble, IF_ID_flush, ID_EX_flush;
   logic       mem_timeout;
   logic [1:0] state;
   logic [7:0] ctrl;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] load_use_cnt, mem_wait_cnt, flush_cnt;
`endif

   int checks = 0;
   int failures = 0;

   // Reference model: error flag, waiting flag, number of wait cycles seen.
   bit m_err, m_wait;
   int m_waited;
   longint m_lu, m_mw, m_fl;

   hazard_detection_unit #(.MEM_TIMEOUT(T)) dut (
      .clk(clk), .reset(reset),
      .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
      .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
      .ID_EX_rd(ID_EX_rd), .ID_EX_mem_read(ID_EX_mem_read),
      .EX_redirect(EX_redirect), .EX_MEM_mem_req(EX_MEM_mem_req),
      .dmem_ready(dmem_ready),
      .pc_write(pc_write), .IF_ID_write(IF_ID_write),
      .ID_EX_write(ID_EX_write), .EX_MEM_write(EX_MEM_write),
      .ID_EX_bubble(ID_EX_bubble), .MEM_WB_bubble(MEM_WB_bubble),
      .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
      .mem_timeout(mem_timeout), .state(state)
`ifdef HAZARD_PERF_CNT_EN
     ,.load_use_cnt(load_use_cnt), .mem_wait_cnt(mem_wait_cnt), .flush_cnt(flush_cnt)
`endif
   );

   assign ctrl = {pc_write, IF_ID_write, ID_EX_write, EX_MEM_write,
                  ID_EX_bubble, MEM_WB_bubble, IF_ID_flush, ID_EX_flush};

   always #5 clk = ~clk;

   function automatic bit m_frozen();
      if (m_err) return 1'b1;
      if (m_wait) return !dmem_ready;
      return EX_MEM_mem_req && !dmem_ready;
   endfunction

   function automatic bit m_load_use();
      if (!ID_EX_mem_read || ID_EX_rd == 0) return 1'b0;
      return (ID_use_rs1 && ID_rs1 == ID_EX_rd) || (ID_use_rs2 && ID_rs2 == ID_EX_rd);
   endfunction

   function automatic logic [7:0] m_ctrl();
      if (m_frozen()) return C_FREEZE;
      if (EX_redirect) return C_REDIR;
      if (m_load_use()) return C_LU;
      return C_RUN;
   endfunction

   function automatic logic [1:0] m_state();
      return m_err ? 2'd2 : (m_wait ? 2'd1 : 2'd0);
   endfunction

   task automatic tick();
      bit f;
      @(posedge clk);
      f = m_frozen();
      if (!reset) begin
         m_err = 0; m_wait = 0; m_waited = 0;
         m_lu = 0; m_mw = 0; m_fl = 0;
      end else begin
         if (f) m_mw++;
         else if (EX_redirect) m_fl++;
         else if (m_load_use()) m_lu++;
         if (m_err) begin
         end else if (m_wait) begin
            if (dmem_ready) m_wait = 0;
            else begin
               m_waited++;
               if (m_waited == T) begin m_err = 1; m_wait = 0; end
            end
         end else if (f) begin
            m_wait = 1; m_waited = 0;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle();
      ID_rs1 = 0; ID_rs2 = 0; ID_EX_rd = 0;
      ID_use_rs1 = 0; ID_use_rs2 = 0; ID_EX_mem_read = 0;
      EX_redirect = 0; EX_MEM_mem_req = 0; dmem_ready = 0;
   endtask

   task automatic pulse_reset();
      idle();
      reset = 0;
      tick();
      reset = 1;
   endtask

   task automatic test_reset();
      pulse_reset();
      #1;
      checks++;
      if (state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", state); end
      checks++;
      if (mem_timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %0b expected 0", mem_timeout); end
      checks++;
      if (ctrl !== C_RUN) begin failures++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, C_RUN); end
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if ({load_use_cnt, mem_wait_cnt, flush_cnt} !== 96'd0) begin
         failures++; $display("FAIL reset_cnt: got %0d/%0d/%0d expected 0/0/0", load_use_cnt, mem_wait_cnt, flush_cnt);
      end
`endif
      tick();
   endtask

   task automatic test_load_use();
      pulse_reset();
      ID_EX_mem_read = 1; ID_EX_rd = 5; ID_rs1 = 5; ID_use_rs1 = 1; ID_rs2 = 1; ID_use_rs2 = 1;
      #1;
      checks++;
      if (ctrl !== C_LU) begin failures++; $display("FAIL load_use_stall: got %b expected %b", ctrl, C_LU); end
      tick();
      ID_EX_mem_read = 0; ID_EX_rd = 0;
      #1;
      checks++;
      if (ctrl !== C_RUN) begin failures++; $display("FAIL load_use_release: got %b expected %b", ctrl, C_RUN); end
      tick();
      ID_EX_mem_read = 1; ID_EX_rd = 7; ID_rs1 = 3; ID_use_rs1 = 1; ID_rs2 = 7; ID_use_rs2 = 1;
      #1;
      checks++;
      if (ctrl !== C_LU) begin failures++; $display("FAIL load_use_rs2: got %b expected %b", ctrl, C_LU); end
      tick();
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if (load_use_cnt !== 32'd2) begin failures++; $display("FAIL load_use_cnt: got %0d expected 2", load_use_cnt); end
`endif
      idle();
   endtask

   task automatic test_no_false_stall();
      idle();
      ID_EX_mem_read = 1; ID_EX_rd = 0; ID_rs1 = 0; ID_use_rs1 = 1;
      #1;
      checks++;
      if (ctrl !== C_RUN) begin failures++; $display("FAIL no_stall_x0: got %b expected %b", ctrl, C_RUN); end
      tick();
      ID_EX_rd = 5; ID_rs1 = 5; ID_use_rs1 = 0; ID_rs2 = 5; ID_use_rs2 = 0;
      #1;
      checks++;
      if (ctrl !== C_RUN) begin failures++; $display("FAIL no_stall_unused: got %b expected %b", ctrl, C_RUN); end
      tick();
      ID_EX_mem_read = 0; ID_use_rs1 = 1;
      #1;
      checks++;
      if (ctrl !== C_RUN) begin failures++; $display("FAIL no_stall_alu: got %b expected %b", ctrl, C_RUN); end
      tick();
      idle();
   endtask

   task automatic test_mem_wait();
      int frz = 0;
      pulse_reset();
      EX_MEM_mem_req = 1; dmem_ready = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (ctrl === C_FREEZE) frz++;
         checks++;
         if (state !== (i == 0 ? 2'd0 : 2'd1)) begin
            failures++; $display("FAIL mem_wait_state[%0d]: got %0d expected %0d", i, state, (i == 0 ? 0 : 1));
         end
         tick();
      end
      checks++;
      if (frz != 3) begin failures++; $display("FAIL mem_wait_freezes: got %0d expected 3", frz); end
      dmem_ready = 1;
      #1;
      checks++;
      if (ctrl !== C_RUN) begin failures++; $display("FAIL mem_wait_unfreeze: got %b expected %b", ctrl, C_RUN); end
      tick();
      idle();
      #1;
      checks++;
      if (state !== 2'd0) begin failures++; $display("FAIL mem_wait_exit: got %0d expected 0", state); end
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if (mem_wait_cnt !== 32'd3) begin failures++; $display("FAIL mem_wait_cnt: got %0d expected 3", mem_wait_cnt); end
`endif
      EX_MEM_mem_req = 1; dmem_ready = 1;
      #1;
      checks++;
      if (ctrl !== C_RUN || state !== 2'd0) begin
         failures++; $display("FAIL mem_ready_first: got %b/%0d expected %b/0", ctrl, state, C_RUN);
      end
      tick();
      idle();
   endtask

   task automatic test_redirect_freeze();
      pulse_reset();
      EX_redirect = 1; EX_MEM_mem_req = 1; dmem_ready = 0;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (ctrl !== C_FREEZE) begin failures++; $display("FAIL redir_hold[%0d]: got %b expected %b", i, ctrl, C_FREEZE); end
         tick();
      end
      dmem_ready = 1;
      ID_EX_mem_read = 1; ID_EX_rd = 4; ID_rs1 = 4; ID_use_rs1 = 1;
      #1;
      checks++;
      if (ctrl !== C_REDIR) begin failures++; $display("FAIL redir_apply: got %b expected %b", ctrl, C_REDIR); end
      tick();
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if (flush_cnt !== 32'd1 || load_use_cnt !== 32'd0) begin
         failures++; $display("FAIL redir_cnt: got %0d/%0d expected 1/0", flush_cnt, load_use_cnt);
      end
`endif
      idle();
   endtask

   task automatic test_timeout();
      pulse_reset();
      EX_MEM_mem_req = 1; dmem_ready = 0;
      tick();
      for (int i = 1; i <= T; i++) begin
         tick();
         #1;
         checks++;
         if (state !== (i == T ? 2'd2 : 2'd1) || mem_timeout !== (i == T)) begin
            failures++; $display("FAIL timeout_progress[%0d]: got %0d/%0b expected %0d/%0b", i, state, mem_timeout, (i == T ? 2 : 1), (i == T));
         end
      end
      dmem_ready = 1;
      #1;
      checks++;
      if (ctrl !== C_FREEZE) begin failures++; $display("FAIL error_freeze: got %b expected %b", ctrl, C_FREEZE); end
      tick();
      #1;
      checks++;
      if (state !== 2'd2 || mem_timeout !== 1'b1) begin
         failures++; $display("FAIL error_sticky: got %0d/%0b expected 2/1", state, mem_timeout);
      end
      pulse_reset();
      #1;
      checks++;
      if (state !== 2'd0 || mem_timeout !== 1'b0) begin
         failures++; $display("FAIL error_reset: got %0d/%0b expected 0/0", state, mem_timeout);
      end
   endtask

   task automatic test_ready_at_timeout();
      pulse_reset();
      EX_MEM_mem_req = 1; dmem_ready = 0;
      for (int i = 0; i < T; i++) tick();
      dmem_ready = 1;
      tick();
      idle();
      #1;
      checks++;
      if (state !== 2'd0 || mem_timeout !== 1'b0) begin
         failures++; $display("FAIL ready_wins: got %0d/%0b expected 0/0", state, mem_timeout);
      end
   endtask

   task automatic test_reset_mid_wait();
      pulse_reset();
      EX_MEM_mem_req = 1; dmem_ready = 0;
      tick(); tick();
      reset = 0;
      tick();
      reset = 1;
      idle();
      #1;
      checks++;
      if (state !== 2'd0 || mem_timeout !== 1'b0) begin
         failures++; $display("FAIL reset_mid_wait: got %0d/%0b expected 0/0", state, mem_timeout);
      end
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if ({load_use_cnt, mem_wait_cnt, flush_cnt} !== 96'd0) begin
         failures++; $display("FAIL reset_mid_wait_cnt: got %0d/%0d/%0d expected 0", load_use_cnt, mem_wait_cnt, flush_cnt);
      end
`endif
      tick();
   endtask

   task automatic test_random();
      pulse_reset();
      for (int n = 0; n < 500; n++) begin
         reset          = ($urandom_range(99) >= 3);
         ID_rs1         = 5'($urandom_range(3));
         ID_rs2         = 5'($urandom_range(3));
         ID_EX_rd       = 5'($urandom_range(3));
         ID_use_rs1     = 1'($urandom_range(1));
         ID_use_rs2     = 1'($urandom_range(1));
         ID_EX_mem_read = 1'($urandom_range(1));
         EX_redirect    = ($urandom_range(4) == 0);
         EX_MEM_mem_req = 1'($urandom_range(1));
         dmem_ready     = ($urandom_range(9) >= 6);
         #1;
         checks++;
         if (ctrl !== m_ctrl() || state !== m_state() || mem_timeout !== m_err) begin
            failures++;
            $display("FAIL random[%0d]: got ctrl=%b st=%0d to=%0b expected ctrl=%b st=%0d to=%0b",
                     n, ctrl, state, mem_timeout, m_ctrl(), m_state(), m_err);
         end
`ifdef HAZARD_PERF_CNT_EN
         checks++;
         if (load_use_cnt !== 32'(m_lu) || mem_wait_cnt !== 32'(m_mw) || flush_cnt !== 32'(m_fl)) begin
            failures++;
            $display("FAIL random_cnt[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d",
                     n, load_use_cnt, mem_wait_cnt, flush_cnt, m_lu, m_mw, m_fl);
         end
`endif
         tick();
      end
      reset = 1;
      idle();
   endtask

   initial begin
      idle();
      reset = 0;
      m_err = 0; m_wait = 0; m_waited = 0; m_lu = 0; m_mw = 0; m_fl = 0;
      tick();
      test_reset();
      test_load_use();
      test_no_false_stall();
      test_mem_wait();
      test_redirect_freeze();
      test_timeout();
      test_ready_at_timeout();
      test_reset_mid_wait();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
